// File: rtl/aesha3_host_link_if.sv
// Signal bundle between the host bus adapter, the host link and the AES/SHA3 core.
// slave = the link itself; master = the surrounding host/core environment.
interface aesha3_host_link_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_mode;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_tag;
  logic       m_last;
  logic [7:0] core_data;
  logic       core_start;
  logic       core_mode;
  logic [7:0] core_rdata;
  logic       core_rvalid;
  logic       core_busy;
  logic       ready;
  logic       err;

  modport slave (
    input  s_data, s_valid, s_mode, m_ready, core_rdata, core_rvalid, core_busy,
    output s_ready, m_data, m_valid, m_tag, m_last, core_data, core_start, core_mode, ready, err
  );

  modport master (
    output s_data, s_valid, s_mode, m_ready, core_rdata, core_rvalid, core_busy,
    input  s_ready, m_data, m_valid, m_tag, m_last, core_data, core_start, core_mode, ready, err
  );
endinterface

// File: rtl/aesha3_host_link.sv
// Host link to the AES/SHA3 core: buffers key/message, bursts it with unbroken core_start, captures
// and replays the 48-byte response with valid/ready backpressure. Optional watchdog: HOST_LINK_TIMEOUT_EN.
module aesha3_host_link #(
  parameter int KEY_BYTES      = 32,
  parameter int MSG_BYTES      = 16,
  parameter int CT_BYTES       = 16,
  parameter int TAG_BYTES      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic              clk,
  input logic              rst_n,
  aesha3_host_link_if.slave link
);
  localparam int RSP_BYTES = CT_BYTES + TAG_BYTES;
  localparam int CW  = $clog2(KEY_BYTES + 1);
  localparam int RW  = $clog2(RSP_BYTES + 1);
  localparam int BW  = $clog2(KEY_BYTES);
  localparam int RBW = $clog2(RSP_BYTES);
  localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] MSG_LAST = CW'(MSG_BYTES - 1);
  localparam logic [RW-1:0] RSP_FULL = RW'(RSP_BYTES);
  localparam logic [RW-1:0] RSP_LAST = RW'(RSP_BYTES - 1);
  localparam logic [RW-1:0] CT_N     = RW'(CT_BYTES);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_KEY_FILL, S_KEY_SEND, S_KDF_WAIT, S_MSG_FILL,
    S_MSG_SEND, S_RESP_WAIT, S_RESP_CAP, S_DRAIN
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] r_dcnt;
  logic          r_seen_busy;
  logic          r_s_ready;
  logic          r_ready;
  logic          r_core_start;
  logic [7:0]    r_core_data;
  logic          r_core_mode;
  logic          r_m_valid;
  logic [7:0]    r_m_data;
  logic          r_m_tag;
  logic          r_m_last;
  logic [7:0]    r_kbuf [KEY_BYTES];
  logic [7:0]    r_rbuf [RSP_BYTES];

  logic           w_s_fire;
  logic           w_m_fire;
  logic           w_resp_st;
  logic           w_cap;
  logic [BW-1:0]  w_bidx;
  logic [RBW-1:0] w_ridx;
  logic [RW-1:0]  w_dnext;
  logic [RBW-1:0] w_didx;
  logic           w_wd_fire;

  assign w_s_fire  = r_s_ready & link.s_valid;
  assign w_m_fire  = r_m_valid & link.m_ready;
  assign w_resp_st = (r_state == S_RESP_WAIT) || (r_state == S_RESP_CAP);
  assign w_cap     = link.core_rvalid && w_resp_st && (r_rcnt != RSP_FULL);
  assign w_bidx    = r_cnt[BW-1:0];
  assign w_ridx    = r_rcnt[RBW-1:0];
  assign w_dnext   = r_dcnt + RW'(1);
  assign w_didx    = w_dnext[RBW-1:0];

`ifdef HOST_LINK_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] r_wdog;
  logic          r_err;
  logic          w_wd_watch;
  logic          w_stray;
  assign w_wd_watch = (r_state == S_KDF_WAIT) || w_resp_st;
  assign w_wd_fire  = w_wd_watch && !link.core_rvalid && (r_wdog == WD_LAST);
  assign w_stray    = link.core_rvalid && !w_resp_st;
  assign link.err   = r_err;
`else
  assign w_wd_fire  = 1'b0;
  assign link.err   = 1'b0;
`endif

  // Payload storage carries no reset; validity is tracked entirely by the FSM counters.
  always_ff @(posedge clk) begin
    if (w_s_fire) r_kbuf[w_bidx] <= link.s_data;
    if (w_cap)    r_rbuf[w_ridx] <= link.core_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_KEY_FILL;
      r_cnt        <= '0;
      r_rcnt       <= '0;
      r_dcnt       <= '0;
      r_seen_busy  <= 1'b0;
      r_s_ready    <= 1'b0;
      r_ready      <= 1'b0;
      r_core_start <= 1'b0;
      r_core_data  <= '0;
      r_core_mode  <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_tag      <= 1'b0;
      r_m_last     <= 1'b0;
`ifdef HOST_LINK_TIMEOUT_EN
      r_wdog       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_core_start <= 1'b0;
      if (w_wd_fire) begin
        r_state     <= S_KEY_FILL;
        r_cnt       <= '0;
        r_rcnt      <= '0;
        r_dcnt      <= '0;
        r_seen_busy <= 1'b0;
        r_s_ready   <= 1'b0;
        r_ready     <= 1'b0;
        r_m_valid   <= 1'b0;
      end else begin
        case (r_state)
          S_KEY_FILL: begin
            r_s_ready <= 1'b1;
            if (w_s_fire) begin
              if (r_cnt == KEY_LAST) begin
                r_cnt     <= '0;
                r_s_ready <= 1'b0;
                r_state   <= S_KEY_SEND;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
          // core_start is registered, so the burst trails the state by one cycle but stays unbroken.
          S_KEY_SEND: begin
            r_core_start <= 1'b1;
            r_core_data  <= r_kbuf[w_bidx];
            if (r_cnt == KEY_LAST) begin
              r_cnt       <= '0;
              r_seen_busy <= 1'b0;
              r_state     <= S_KDF_WAIT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_KDF_WAIT: begin
            if (!r_seen_busy) begin
              r_seen_busy <= link.core_busy;
            end else if (!link.core_busy) begin
              r_cnt     <= '0;
              r_s_ready <= 1'b1;
              r_ready   <= 1'b1;
              r_state   <= S_MSG_FILL;
            end
          end
          S_MSG_FILL: begin
            if (w_s_fire) begin
              r_ready <= 1'b0;
              if (r_cnt == '0) r_core_mode <= link.s_mode;
              if (r_cnt == MSG_LAST) begin
                r_cnt     <= '0;
                r_s_ready <= 1'b0;
                r_state   <= S_MSG_SEND;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
          end
          S_MSG_SEND: begin
            r_core_start <= 1'b1;
            r_core_data  <= r_kbuf[w_bidx];
            if (r_cnt == MSG_LAST) begin
              r_cnt   <= '0;
              r_rcnt  <= '0;
              r_state <= S_RESP_WAIT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          // Only the capture position matters, so gaps between cipher and HMAC bytes are harmless.
          S_RESP_WAIT, S_RESP_CAP: begin
            if (w_cap) begin
              r_rcnt  <= r_rcnt + RW'(1);
              r_state <= S_RESP_CAP;
            end
            if ((r_rcnt == RSP_FULL) && !link.core_busy) begin
              r_dcnt    <= '0;
              r_m_valid <= 1'b1;
              r_m_data  <= r_rbuf[0];
              r_m_tag   <= 1'b0;
              r_m_last  <= 1'b0;
              r_state   <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (w_m_fire) begin
              if (r_dcnt == RSP_LAST) begin
                r_m_valid <= 1'b0;
                r_m_tag   <= 1'b0;
                r_m_last  <= 1'b0;
                r_cnt     <= '0;
                r_rcnt    <= '0;
                r_s_ready <= 1'b1;
                r_ready   <= 1'b1;
                r_state   <= S_MSG_FILL;
              end else begin
                r_dcnt   <= w_dnext;
                r_m_data <= r_rbuf[w_didx];
                r_m_tag  <= (w_dnext >= CT_N);
                r_m_last <= (w_dnext == RSP_LAST);
              end
            end
          end
          default: r_state <= S_KEY_FILL;
        endcase
      end
`ifdef HOST_LINK_TIMEOUT_EN
      if (!w_wd_watch || link.core_rvalid) r_wdog <= '0;
      else                                 r_wdog <= r_wdog + WW'(1);
      if (w_wd_fire || w_stray) r_err <= 1'b1;
`endif
    end
  end

  assign link.s_ready    = r_s_ready;
  assign link.ready      = r_ready;
  assign link.core_start = r_core_start;
  assign link.core_data  = r_core_data;
  assign link.core_mode  = r_core_mode;
  assign link.m_valid    = r_m_valid;
  assign link.m_data     = r_m_data;
  assign link.m_tag      = r_m_tag;
  assign link.m_last     = r_m_last;
endmodule

// File: doc/aesha3_host_link.md
Name: aesha3_host_link

Overview:
- Host-side end of the AES/SHA3 core's byte-serial interface.
- Buffers a 32-byte salt+key load, or a 16-byte message, from a host valid/ready byte stream. Then bursts it to the core with core_start held contiguously.
- Captures the core's unthrottled response (16 cipher bytes, then 32 HMAC bytes) and replays it to the host with valid/ready backpressure.
- Sits between the system bus adapter and the core top level, in the same clock domain.

Parameters:
- KEY_BYTES, 32, bytes in the salt+key load (salt first, then key).
- MSG_BYTES, 16, bytes per message block.
- CT_BYTES, 16, cipher bytes returned per message.
- TAG_BYTES, 32, HMAC bytes returned per message.
- TIMEOUT_CYCLES, 4096, watchdog limit. Used only with HOST_LINK_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_data  in  8  host byte in
- s_valid  in  1  host byte valid
- s_ready  out  1  link accepts host byte
- s_mode  in  1  cipher mode for the message, sampled with its first byte
- m_data  out  8  response byte to host
- m_valid  out  1  response byte valid
- m_ready  in  1  host accepts response byte
- m_tag  out  1  0 = cipher byte, 1 = HMAC byte
- m_last  out  1  final HMAC byte of a response
- core_data  out  8  byte to core
- core_start  out  1  byte strobe to core; contiguous for a whole burst
- core_mode  out  1  cipher mode to core
- core_rdata  in  8  core output byte
- core_rvalid  in  1  core output valid
- core_busy  in  1  core input-enable (1 = core busy, 0 = core accepting)
- ready  out  1  link idle in MSG_FILL with empty buffers
- err  out  1  sticky watchdog error (feature only; otherwise tied 0)

Behaviour:
- Reset values: all outputs 0, state KEY_FILL, all counters 0.
- Reset is honoured mid-operation: buffers are discarded and the block returns to KEY_FILL.
- States and transitions:
  - KEY_FILL: s_ready=1. Each s_valid&s_ready writes the byte into the 32-byte buffer at index cnt. After byte KEY_BYTES-1 -> KEY_SEND, cnt=0.
  - KEY_SEND: core_start=1 and core_data=buf[cnt] for exactly KEY_BYTES consecutive cycles, buffer order (byte 0 first). s_ready=0. Then -> KDF_WAIT.
  - KDF_WAIT: wait for core_busy=1, then for core_busy=0 -> MSG_FILL.
  - MSG_FILL: s_ready=1 and ready=1 while the output buffer is empty.
    - s_mode is latched into core_mode on the first accepted byte.
    - After MSG_BYTES accepted -> MSG_SEND.
  - MSG_SEND: MSG_BYTES contiguous core_start cycles, then core_start=0 -> RESP_WAIT.
  - RESP_WAIT / RESP_CAP:
    - Every cycle with core_rvalid=1 writes core_rdata to the 48-byte response buffer at rcnt; rcnt increments.
    - A non-valid gap between the cipher and HMAC segments is tolerated; only rcnt position matters.
    - When rcnt=CT_BYTES+TAG_BYTES and core_busy=0 -> DRAIN.
  - DRAIN:
    - m_valid=1 with m_data=rbuf[dcnt]; advance on m_valid&m_ready.
    - m_tag=(dcnt>=CT_BYTES). m_last=(dcnt==47).
    - After the last handshake -> MSG_FILL.
- Response bytes are forwarded unmodified, in the order received.
- core_start is never asserted outside KEY_SEND/MSG_SEND. The core zero-pads on gaps, so a burst must never be broken.
- The key is loaded once per reset; there is no re-key path.
- core_rvalid outside RESP_WAIT/RESP_CAP is ignored. It sets err when HOST_LINK_TIMEOUT_EN is defined.
- m_data is held stable while m_valid=1 and m_ready=0.
- s_valid while s_ready=0: the byte is not consumed.
- Counters are sized ceil(log2(max count + 1)) and never wrap within a phase.

Optional Feature:
- Macro: HOST_LINK_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in KDF_WAIT, RESP_WAIT and RESP_CAP, and clears on every state change or core_rvalid.
  - On reaching TIMEOUT_CYCLES: set sticky err, discard buffers, go to KEY_FILL.
  - err clears only on reset.
- Undefined: no watchdog; the block waits indefinitely and err is constant 0.

Test Plan:
- Key load: host sends bytes 0x00..0x1F back-to-back -> core_start high exactly 32 consecutive cycles, core_data 0x00..0x1F in order. No start until the 32nd byte is accepted.
- Stalled key fill: the same bytes with s_valid low on alternate cycles -> the core burst is still 32 contiguous cycles with identical data.
- Message round trip with a core model:
  - Stimulus: core_busy pulses after the key; message 0x00112233..FF with s_mode=1; core returns 16 bytes 0xA0..0xAF, one gap cycle, then 32 bytes 0xC0..0xDF.
  - Expected: core_mode=1 and a 16-cycle burst. Host receives 48 bytes in order; m_tag=0 for the first 16; m_last only on 0xDF.
- Backpressure: m_ready toggles every 3 cycles during DRAIN -> no byte lost or duplicated, and m_data is stable while stalled. s_ready stays 0 until the drain completes.
- Reset mid-RESP_CAP after 10 captured bytes -> outputs 0, state KEY_FILL, and a fresh key load works.
- With HOST_LINK_TIMEOUT_EN, TIMEOUT_CYCLES=64, and core_busy held low after a message -> err=1 at cycle 64 of RESP_WAIT, then KEY_FILL. Without the macro: no err and the block stays in RESP_WAIT.
